// File: rtl/uart_lcd_cmd_ctrl_if.sv
// uart_lcd_cmd_ctrl_if: UART byte stream in, LCD write handshake and status out
interface uart_lcd_cmd_ctrl_if #(
   parameter int FIFO_DEPTH = 16
);
   logic                        rx_done_tick;
   logic [7:0]                  rx_byte;
   logic                        lcd_busy;
   logic                        lcd_start;
   logic                        lcd_rs;
   logic [7:0]                  lcd_data;
   logic [$clog2(FIFO_DEPTH):0] fifo_level;
   logic                        overflow;
   logic                        init_done;
   modport master (
      output rx_done_tick, rx_byte, lcd_busy,
      input  lcd_start, lcd_rs, lcd_data, fifo_level, overflow, init_done
   );
   modport slave (
      input  rx_done_tick, rx_byte, lcd_busy,
      output lcd_start, lcd_rs, lcd_data, fifo_level, overflow, init_done
   );
endinterface

// File: rtl/uart_lcd_cmd_ctrl.sv
// uart_lcd_cmd_ctrl: ESC-protocol parser feeding a write FIFO drained by an LCD start/busy issuer; INIT_SEQ_EN adds a power-up command sequence
module uart_lcd_cmd_ctrl #(
   parameter int         FIFO_DEPTH  = 16,
   parameter logic [7:0] ESC_CODE    = 8'h1B,
   parameter int         ESC_TIMEOUT = 24000
) (
   input logic                clk,
   input logic                reset,
   uart_lcd_cmd_ctrl_if.slave bus
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam int TW = $clog2(ESC_TIMEOUT + 1);
   typedef enum logic {P_NORMAL, P_ESC} p_state_t;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_HOLD, S_WAIT} s_state_t;
   p_state_t      r_pstate, w_pstate_nx;
   s_state_t      r_state, w_state_nx;
   logic [TW-1:0] r_esc_cnt;
   logic [8:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [LW-1:0] r_level;
   logic          r_overflow, r_lcd_rs;
   logic [7:0]    r_lcd_data;
   logic          w_push, w_wr, w_pop, w_load, w_full, w_empty, w_init_done;
   logic [8:0]    w_push_entry, w_load_entry;
   assign w_full  = r_level == LW'(FIFO_DEPTH);
   assign w_empty = r_level == '0;
   assign w_wr    = w_push && (!w_full || w_pop);
   // Parser: classify each received byte as data, command or escape prefix
   always_comb begin
      w_pstate_nx  = r_pstate;
      w_push       = 1'b0;
      w_push_entry = {1'b1, bus.rx_byte};
      if (bus.rx_done_tick) begin
         w_pstate_nx = bus.rx_byte == ESC_CODE && r_pstate == P_NORMAL ? P_ESC : P_NORMAL;
         w_push      = r_pstate == P_ESC || bus.rx_byte != ESC_CODE;
         if (r_pstate == P_ESC) w_push_entry = {bus.rx_byte == ESC_CODE, bus.rx_byte};
      end else if (r_pstate == P_ESC && r_esc_cnt == TW'(ESC_TIMEOUT - 1)) begin
         w_pstate_nx = P_NORMAL;
      end
   end
   // Parser state and escape timeout counter; the counter only runs while an ESC waits
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pstate  <= P_NORMAL;
         r_esc_cnt <= '0;
      end else begin
         r_pstate  <= w_pstate_nx;
         r_esc_cnt <= r_pstate == P_ESC && !bus.rx_done_tick ? r_esc_cnt + TW'(1) : '0;
      end
   end
   // FIFO pointers, occupancy and sticky overflow
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr     <= '0;
         r_rptr     <= '0;
         r_level    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr) r_wptr <= r_wptr + AW'(1);
         if (w_pop) r_rptr <= r_rptr + AW'(1);
         r_level <= r_level + LW'(w_wr) - LW'(w_pop);
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end
   // FIFO storage needs no reset; occupancy decides what is valid
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wptr] <= w_push_entry;
   end
   // Issuer state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else r_state <= w_state_nx;
   end
   // Issuer next state: one write in flight; busy is ignored in the cycle after start
   always_comb begin
      w_state_nx = r_state;
      case (r_state)
         S_IDLE:  w_state_nx = w_load ? S_ISSUE : S_IDLE;
         S_ISSUE: w_state_nx = S_HOLD;
         S_HOLD:  w_state_nx = S_WAIT;
         default: w_state_nx = bus.lcd_busy ? S_WAIT : S_IDLE;
      endcase
   end
   // Issuer outputs: load a write when idle and the driver is free; FIFO pops only after init
   always_comb begin
      w_load        = r_state == S_IDLE && !bus.lcd_busy && (!w_init_done || !w_empty);
      w_pop         = w_load && w_init_done;
      bus.lcd_start = r_state == S_ISSUE;
   end
   // Write register held stable from one start until the next
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) {r_lcd_rs, r_lcd_data} <= 9'h000;
      else if (w_load) {r_lcd_rs, r_lcd_data} <= w_load_entry;
   end
`ifdef INIT_SEQ_EN
   logic [1:0] r_init_idx;
   logic       r_init_done;
   logic [7:0] w_init_cmd;
   assign w_init_cmd = r_init_idx == 2'd0 ? 8'h38 : r_init_idx == 2'd1 ? 8'h0C : r_init_idx == 2'd2 ? 8'h06 : 8'h01;
   // Init sequencer advances each time a command finishes its busy wait
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_init_idx  <= 2'd0;
         r_init_done <= 1'b0;
      end else if (!r_init_done && r_state == S_WAIT && !bus.lcd_busy) begin
         r_init_idx <= r_init_idx + 2'd1;
         if (r_init_idx == 2'd3) r_init_done <= 1'b1;
      end
   end
   assign w_init_done  = r_init_done;
   assign w_load_entry = r_init_done ? r_mem[r_rptr] : {1'b0, w_init_cmd};
`else
   assign w_init_done  = 1'b1;
   assign w_load_entry = r_mem[r_rptr];
`endif
   assign bus.lcd_rs     = r_lcd_rs;
   assign bus.lcd_data   = r_lcd_data;
   assign bus.fifo_level = r_level;
   assign bus.overflow   = r_overflow;
   assign bus.init_done  = w_init_done;
endmodule

// File: tb/tb_uart_lcd_cmd_ctrl.sv
// tb_uart_lcd_cmd_ctrl: scoreboard bench with a byte-level protocol model and a start monitor
module tb_uart_lcd_cmd_ctrl;
   localparam int         DEPTH = 16;
   localparam int         ESC_T = 40;
   localparam logic [7:0] ESC   = 8'h1B;
   logic clk = 0;
   logic reset = 1;
   uart_lcd_cmd_ctrl_if #(.FIFO_DEPTH(DEPTH)) bus ();
   uart_lcd_cmd_ctrl #(.FIFO_DEPTH(DEPTH), .ESC_CODE(ESC), .ESC_TIMEOUT(ESC_T)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   int cyc = 0, checks = 0, errors = 0, pushed = 0, started = 0, busy_len = 5;
   int last_start = -100, first_start = -1, tick_cyc = 0, esc_cyc = 0;
   bit busy_force = 0, esc_pend = 0;
   logic exp_ovf = 0;
   logic [8:0] exp_q[$];
   logic [8:0] e_mon;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   // Protocol model: ESC then a byte within ESC_T cycles is an escape pair; FIFO holds DEPTH writes
   function automatic void model_byte(input logic [7:0] b);
      logic       esc_live;
      logic [8:0] ent;
      esc_live = esc_pend && (cyc - esc_cyc <= ESC_T);
      esc_pend = 0;
      if (!esc_live && b == ESC) begin
         esc_pend = 1;
         esc_cyc  = cyc;
         return;
      end
      ent = esc_live ? {b == ESC, b} : {1'b1, b};
      if (pushed - started >= DEPTH) exp_ovf = 1;
      else begin
         exp_q.push_back(ent);
         pushed++;
      end
   endfunction
   task automatic send(input logic [7:0] b);
      bus.rx_byte = b;
      bus.rx_done_tick = 1;
      model_byte(b);
      @(negedge clk);
      bus.rx_done_tick = 0;
   endtask
   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bus.lcd_busy) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk(name, exp_q.size(), 0);
   endtask
   task automatic model_reset();
      exp_q.delete();
      esc_pend = 0;
      pushed = 0;
      started = 0;
      exp_ovf = 0;
      last_start = -100;
   endtask
   task automatic model_release();
`ifdef INIT_SEQ_EN
      exp_q.push_back(9'h038);
      exp_q.push_back(9'h00C);
      exp_q.push_back(9'h006);
      exp_q.push_back(9'h001);
      pushed += 4;
`endif
   endtask
   // LCD driver model: busy from the cycle after start for busy_len cycles (random when negative)
   initial begin
      bus.lcd_busy = 0;
      forever begin
         @(negedge clk);
         if (busy_force) bus.lcd_busy = 1;
         else if (bus.lcd_start && reset) begin
            bus.lcd_busy = 1;
            repeat (busy_len < 0 ? int'($urandom_range(1, 6)) : busy_len) @(negedge clk);
            bus.lcd_busy = 0;
         end else bus.lcd_busy = 0;
      end
   end
   // Monitor: every start must match the scoreboard head, never overlap busy, and be spaced >= 4 cycles
   always @(posedge clk) begin
      #1;
      if (reset && bus.lcd_start) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_start: got %0h expected none", {bus.lcd_rs, bus.lcd_data});
         end else begin
            e_mon = exp_q.pop_front();
            if ({bus.lcd_rs, bus.lcd_data} !== e_mon) begin
               errors++;
               $display("FAIL write: got %0h expected %0h", {bus.lcd_rs, bus.lcd_data}, e_mon);
            end
         end
         checks++;
         if (bus.lcd_busy || cyc - last_start < 4) begin
            errors++;
            $display("FAIL start_timing: got busy=%0d gap=%0d expected busy=0 gap>=4", bus.lcd_busy, cyc - last_start);
         end
         if (first_start < 0) first_start = cyc;
         last_start = cyc;
         started++;
      end
   end
   initial begin
      int g, n;
      bus.rx_done_tick = 0;
      bus.rx_byte = 0;
      #2 reset = 0;
      #1;
      model_reset();
      chk("rst_start", bus.lcd_start, 0);
      chk("rst_rs", bus.lcd_rs, 0);
      chk("rst_data", bus.lcd_data, 0);
      chk("rst_level", bus.fifo_level, 0);
      chk("rst_overflow", bus.overflow, 0);
`ifdef INIT_SEQ_EN
      chk("rst_init_done", bus.init_done, 0);
`else
      chk("rst_init_done", bus.init_done, 1);
`endif
      repeat (3) @(negedge clk);
      reset = 1;
      model_release();
`ifdef INIT_SEQ_EN
      send(8'h55);
      repeat (3) @(negedge clk);
      chk("init_busy", bus.init_done, 0);
      drain("init_drain");
      chk("init_done", bus.init_done, 1);
`endif
      repeat (2) @(negedge clk);
      first_start = -1;
      tick_cyc = cyc;
      send(8'h41);
      repeat (2) @(negedge clk);
      send(8'h42);
      drain("ab_drain");
      chk("latency", first_start - tick_cyc, 2);
      send(ESC);
      send(8'h01);
      drain("esc_cmd_drain");
      send(ESC);
      send(ESC);
      drain("esc_lit_drain");
      send(ESC);
      repeat (ESC_T - 1) @(negedge clk);
      send(8'h45);
      drain("esc_edge_drain");
      send(ESC);
      repeat (ESC_T) @(negedge clk);
      send(8'h30);
      drain("esc_timeout_drain");
      busy_len = -1;
      for (int i = 0; i < 300; i++) begin
         n = 0;
         while (pushed - started >= DEPTH - 2 && n < 1000) begin
            @(negedge clk);
            n++;
         end
         send($urandom_range(0, 3) == 0 ? ESC : 8'($urandom));
         g = $urandom_range(0, 9);
         g = g < 6 ? g % 3 : ESC_T - 8 + g;
         repeat (g) @(negedge clk);
      end
      drain("random_drain");
      chk("no_overflow", bus.overflow, 0);
      repeat (ESC_T + 5) @(negedge clk);
      busy_force = 1;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 17; i++) send(8'h60 + 8'(i));
      @(negedge clk);
      chk("full_level", bus.fifo_level, DEPTH);
      chk("overflow_set", bus.overflow, exp_ovf);
      busy_force = 0;
      drain("ovf_drain");
      chk("overflow_sticky", bus.overflow, 1);
      busy_len = 40;
      send(8'h11);
      repeat (6) @(negedge clk);
      send(8'h12);
      send(8'h13);
      send(8'h14);
      repeat (3) @(negedge clk);
      chk("level_pre_reset", bus.fifo_level, 3);
      reset = 0;
      #1;
      model_reset();
      chk("mid_rst_start", bus.lcd_start, 0);
      chk("mid_rst_level", bus.fifo_level, 0);
      chk("mid_rst_overflow", bus.overflow, 0);
      repeat (3) @(negedge clk);
      reset = 1;
      model_release();
      busy_len = -1;
      repeat (30) @(negedge clk);
      chk("post_rst_level", bus.fifo_level, 0);
      drain("final_drain");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
